sonar_rx_decoder: RTL and testbench
===================================

Name: sonar_rx_decoder

Overview:
- Receiving end of the sonar serial link. Deserialises the 7O1 UART stream: 7 data bits, odd parity, 1 stop bit, LSB first.
- Parses the sonar frame "AAA,DDD#", where AAA is the angle and DDD the distance, each as three ASCII decimal digits.
- Presents both fields as 3-digit BCD with a one-cycle pronto pulse.
- Sits on the host/monitor side of the link, fed from the pin that the sonar transmitter drives.

Parameters:
- CICLOS_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud).
- N, 9, width of the bit-period counter (must hold CICLOS_BIT-1).

Ports:
- clock  input  1  system clock; everything on the rising edge.
- reset  input  1  synchronous, active-high reset.
- entrada_serial  input  1  asynchronous serial line, idle high.
- angulo  output  12  BCD angle; [11:8] hundreds, [7:4] tens, [3:0] units.
- medida  output  12  BCD distance, same digit layout.
- pronto  output  1  one-cycle pulse when a valid frame updates angulo/medida.
- erro  output  1  one-cycle pulse on any character or frame error.
- db_estado  output  4  parser state encoding, for debug.
- db_dado  output  7  last received character, for debug.

Behaviour:
- Reset:
  - Synchronous and dominant over every simultaneous event.
  - Forces angulo=0, medida=0, pronto=0, erro=0, db_dado=0, receiver to IDLE, parser to P0.
  - Reset mid-character discards that character; no erro.
- Input path: entrada_serial passes through a 2-flop synchronizer. All references below are to the synchronized signal.
- Receiver FSM (IDLE, START, DADOS, PARIDADE, STOP):
  - IDLE: a 1->0 transition enters START with the bit counter cleared.
  - START: at count CICLOS_BIT/2 the line is sampled. If 1, treat as a glitch and return to IDLE silently. If 0, enter DADOS.
  - DADOS: sample every CICLOS_BIT cycles at mid-bit; 7 data bits LSB first.
  - PARIDADE: sample the parity bit. The total number of 1s in the 7 data bits plus parity must be odd.
  - STOP: sample the stop bit, which must be 1. On the next cycle emit an internal char_valido pulse (or char_erro if parity is wrong or stop=0), then go to IDLE.
  - If the stop bit is 0, return to IDLE only after the line reads 1; no false start from a held-low line.
- Parser FSM (positions P0..P7, plus RESYNC):
  - P0..P2 expect a digit (0x30..0x39). Digit[3:0] goes into shadow angle nibbles [11:8], [7:4], [3:0] in that order.
  - P3 expects ',' (0x2C).
  - P4..P6 expect digits, which fill the shadow distance nibbles in the same order.
  - P7 expects '#' (0x23).
  - Each accepted char_valido advances one position.
  - Valid '#' at P7: on the next cycle copy both shadows to angulo/medida, pulse pronto, return to P0.
- Error handling:
  - An unexpected character, or a char_erro, at any position pulses erro for 1 cycle, with no output update, and enters RESYNC.
  - RESYNC discards characters until a valid '#', then goes to P0.
  - A char_erro while in RESYNC pulses erro again and stays in RESYNC.
- Outputs hold their last valid frame until the next valid frame; they never change partially.
- pronto and erro are never high in the same cycle.
- db_dado updates on every char_valido.
- Latency: pronto rises 2 cycles after the mid-stop-bit sample of '#'.
- Back-to-back characters with zero idle bits between the stop bit and the next start bit must be received correctly.

Test Plan:
- Frame "045,123#" at CICLOS_BIT=434 -> angulo=12'h045, medida=12'h123, exactly one pronto pulse, erro never high.
- Two back-to-back frames "000,010#" then "180,999#" with no idle gap -> two pronto pulses; final angulo=12'h180, medida=12'h999.
- Parity flipped on the third character of "090,050#" -> one erro pulse, no pronto, outputs keep the previous frame. The following valid frame "135,007#" is decoded (RESYNC consumes the corrupted frame's '#').
- Frame "04X,123#" -> erro on 'X', no update. Same for ";" at P3 or a missing '#' (digit at P7).
- Low glitch of 100 cycles on an idle line -> no character, no erro, db_dado unchanged.
- reset asserted mid-way through the fifth character -> all outputs 0. A frame starting after reset is released decodes normally.

Source files
------------

// File: rtl/sonar_rx_decoder.sv
// Purpose: 7O1 UART receiver plus "AAA,DDD#" frame parser that presents angle/distance as 3-digit BCD.
// Latency: pronto rises 2 cycles after the mid-stop-bit sample of '#' (the pin adds 2 more sync cycles).
// Backpressure: none; the serial line cannot be stalled, so every character is consumed as it arrives.
module sonar_rx_decoder #(
  parameter int CICLOS_BIT = 434,
  parameter int N          = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado,
  output logic [6:0]  db_dado
);

  localparam logic [N-1:0] MEIO   = N'(CICLOS_BIT / 2);
  localparam logic [N-1:0] ULTIMO = N'(CICLOS_BIT - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DADOS, R_PARIDADE, R_STOP
  } rx_estado_t;

  typedef enum logic [3:0] {
    P0, P1, P2, P3, P4, P5, P6, P7, RESYNC
  } ps_estado_t;

  // ---------------- input synchronizer ----------------
  logic sinc1_q, sinc2_q, ant_q;

  // two-flop synchronizer, plus one extra stage so a 1->0 edge can be seen
  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1_q <= 1'b1;
      sinc2_q <= 1'b1;
      ant_q   <= 1'b1;
    end else begin
      sinc1_q <= entrada_serial;
      sinc2_q <= sinc1_q;
      ant_q   <= sinc2_q;
    end
  end

  // ---------------- character receiver ----------------
  rx_estado_t   rx_estado_q, rx_estado_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  logic [6:0]   dado_q, dado_d;
  logic         par_q, par_d;
  logic         char_vld_q, char_vld_d;
  logic         char_err_q, char_err_d;

  // receiver state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_estado_q <= R_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      dado_q      <= '0;
      par_q       <= 1'b0;
      char_vld_q  <= 1'b0;
      char_err_q  <= 1'b0;
    end else begin
      rx_estado_q <= rx_estado_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      dado_q      <= dado_d;
      par_q       <= par_d;
      char_vld_q  <= char_vld_d;
      char_err_q  <= char_err_d;
    end
  end

  // receiver next state: mid-bit sampling; a held-low line never restarts since a 1->0 edge is required
  always_comb begin
    rx_estado_d = rx_estado_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    dado_d      = dado_q;
    par_d       = par_q;
    char_vld_d  = 1'b0;
    char_err_d  = 1'b0;
    case (rx_estado_q)
      R_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (ant_q && !sinc2_q) rx_estado_d = R_START;
      end
      R_START: begin
        if (cnt_q == MEIO) begin
          cnt_d       = '0;
          rx_estado_d = sinc2_q ? R_IDLE : R_DADOS;
        end
      end
      R_DADOS: begin
        if (cnt_q == ULTIMO) begin
          cnt_d  = '0;
          dado_d = {sinc2_q, dado_q[6:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd6) rx_estado_d = R_PARIDADE;
        end
      end
      R_PARIDADE: begin
        if (cnt_q == ULTIMO) begin
          cnt_d       = '0;
          par_d       = sinc2_q;
          rx_estado_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == ULTIMO) begin
          cnt_d       = '0;
          rx_estado_d = R_IDLE;
          if (sinc2_q && (^{dado_q, par_q})) char_vld_d = 1'b1;
          else                               char_err_d = 1'b1;
        end
      end
      default: rx_estado_d = R_IDLE;
    endcase
  end

  // ---------------- frame parser ----------------
  ps_estado_t  ps_estado_q, ps_estado_d;
  logic [11:0] ang_sh_q, ang_sh_d;
  logic [11:0] med_sh_q, med_sh_d;
  logic        fim_q, fim_d;
  logic        erro_q, erro_d;
  logic        pronto_q;
  logic [11:0] angulo_q, medida_q;
  logic [6:0]  db_dado_q;
  logic        eh_digito;

  assign eh_digito = (dado_q >= 7'h30) && (dado_q <= 7'h39);

  // parser state, shadow fields and the one-cycle "frame complete" flag
  always_ff @(posedge clock) begin
    if (reset) begin
      ps_estado_q <= P0;
      ang_sh_q    <= '0;
      med_sh_q    <= '0;
      fim_q       <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      ps_estado_q <= ps_estado_d;
      ang_sh_q    <= ang_sh_d;
      med_sh_q    <= med_sh_d;
      fim_q       <= fim_d;
      erro_q      <= erro_d;
    end
  end

  // parser next state: fill shadows digit by digit; any surprise drops to RESYNC until a good '#'
  always_comb begin
    ps_estado_d = ps_estado_q;
    ang_sh_d    = ang_sh_q;
    med_sh_d    = med_sh_q;
    fim_d       = 1'b0;
    erro_d      = 1'b0;
    if (char_err_q) begin
      erro_d      = 1'b1;
      ps_estado_d = RESYNC;
    end else if (char_vld_q) begin
      case (ps_estado_q)
        P0, P1, P2: begin
          if (eh_digito) begin
            if (ps_estado_q == P0)      ang_sh_d[11:8] = dado_q[3:0];
            else if (ps_estado_q == P1) ang_sh_d[7:4]  = dado_q[3:0];
            else                        ang_sh_d[3:0]  = dado_q[3:0];
            ps_estado_d = ps_estado_t'(ps_estado_q + 4'd1);
          end else begin
            erro_d      = 1'b1;
            ps_estado_d = RESYNC;
          end
        end
        P3: begin
          if (dado_q == 7'h2C) begin
            ps_estado_d = P4;
          end else begin
            erro_d      = 1'b1;
            ps_estado_d = RESYNC;
          end
        end
        P4, P5, P6: begin
          if (eh_digito) begin
            if (ps_estado_q == P4)      med_sh_d[11:8] = dado_q[3:0];
            else if (ps_estado_q == P5) med_sh_d[7:4]  = dado_q[3:0];
            else                        med_sh_d[3:0]  = dado_q[3:0];
            ps_estado_d = ps_estado_t'(ps_estado_q + 4'd1);
          end else begin
            erro_d      = 1'b1;
            ps_estado_d = RESYNC;
          end
        end
        P7: begin
          if (dado_q == 7'h23) begin
            fim_d       = 1'b1;
            ps_estado_d = P0;
          end else begin
            erro_d      = 1'b1;
            ps_estado_d = RESYNC;
          end
        end
        RESYNC: begin
          if (dado_q == 7'h23) ps_estado_d = P0;
        end
        default: ps_estado_d = P0;
      endcase
    end
  end

  // output registers: both fields commit together, one cycle after the '#' was accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      pronto_q  <= 1'b0;
      angulo_q  <= '0;
      medida_q  <= '0;
      db_dado_q <= '0;
    end else begin
      pronto_q <= fim_q;
      if (fim_q) begin
        angulo_q <= ang_sh_q;
        medida_q <= med_sh_q;
      end
      if (char_vld_q) db_dado_q <= dado_q;
    end
  end

  assign angulo    = angulo_q;
  assign medida    = medida_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = ps_estado_q;
  assign db_dado   = db_dado_q;

endmodule

// File: tb/tb_sonar_rx_decoder.sv
// Purpose: directed bench for sonar_rx_decoder driving 7O1 characters onto the serial pin.
// Latency: checks are taken a few cycles after each frame's stop bit, once pronto has had time to fire.
// Backpressure: none; the bench only drives the line and observes outputs.
module tb_sonar_rx_decoder;

  localparam int CB = 40;
  localparam int NB = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        entrada_serial = 1'b1;
  logic [11:0] angulo, medida;
  logic        pronto, erro;
  logic [3:0]  db_estado;
  logic [6:0]  db_dado;

  int total = 0;
  int bad   = 0;
  int n_pronto = 0;
  int n_erro   = 0;
  int n_ambos  = 0;
  int p0, e0;

  sonar_rx_decoder #(.CICLOS_BIT(CB), .N(NB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .angulo         (angulo),
    .medida         (medida),
    .pronto         (pronto),
    .erro           (erro),
    .db_estado      (db_estado),
    .db_dado        (db_dado)
  );

  always #5 clock = ~clock;

  // pulse counters, sampled away from the active edge
  always @(negedge clock) begin
    if (pronto) n_pronto++;
    if (erro) n_erro++;
    if (pronto && erro) n_ambos++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    entrada_serial = b;
    repeat (CB) @(negedge clock);
  endtask

  // start, 7 data LSB first, odd parity (optionally inverted), stop
  task automatic send_char(input logic [7:0] c, input bit flip);
    logic [6:0] d;
    logic       p;
    d = c[6:0];
    p = ~(^d) ^ flip;
    put_bit(1'b0);
    for (int i = 0; i < 7; i++) put_bit(d[i]);
    put_bit(p);
    put_bit(1'b1);
  endtask

  task automatic send_frame(input string s, input int flip_idx);
    for (int i = 0; i < s.len(); i++) send_char(s[i], i == flip_idx);
  endtask

  task automatic mark;
    p0 = n_pronto;
    e0 = n_erro;
  endtask

  initial begin
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_ang",    32'(angulo),    32'h0);
    chk("rst_med",    32'(medida),    32'h0);
    chk("rst_pronto", 32'(pronto),    32'h0);
    chk("rst_erro",   32'(erro),      32'h0);
    chk("rst_dado",   32'(db_dado),   32'h0);
    chk("rst_estado", 32'(db_estado), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // single good frame
    mark();
    send_frame("045,123#", -1);
    repeat (10) @(negedge clock);
    chk("f1_ang",    32'(angulo),    32'h045);
    chk("f1_med",    32'(medida),    32'h123);
    chk("f1_npr",    32'(n_pronto - p0), 32'd1);
    chk("f1_nerr",   32'(n_erro - e0),   32'd0);
    chk("f1_dado",   32'(db_dado),   32'h23);
    chk("f1_estado", 32'(db_estado), 32'h0);

    // back-to-back frames, no idle bits anywhere
    mark();
    send_frame("000,010#", -1);
    send_frame("180,999#", -1);
    repeat (10) @(negedge clock);
    chk("b2b_npr",  32'(n_pronto - p0), 32'd2);
    chk("b2b_nerr", 32'(n_erro - e0),   32'd0);
    chk("b2b_ang",  32'(angulo), 32'h180);
    chk("b2b_med",  32'(medida), 32'h999);

    // parity error on third char; RESYNC eats that frame's '#'
    mark();
    send_frame("090,050#", 2);
    repeat (10) @(negedge clock);
    chk("par_nerr",   32'(n_erro - e0),   32'd1);
    chk("par_npr",    32'(n_pronto - p0), 32'd0);
    chk("par_ang",    32'(angulo), 32'h180);
    chk("par_med",    32'(medida), 32'h999);
    chk("par_estado", 32'(db_estado), 32'h0);
    mark();
    send_frame("135,007#", -1);
    repeat (10) @(negedge clock);
    chk("rec1_npr", 32'(n_pronto - p0), 32'd1);
    chk("rec1_ang", 32'(angulo), 32'h135);
    chk("rec1_med", 32'(medida), 32'h007);

    // non-digit in the angle field
    mark();
    send_frame("04X,123#", -1);
    repeat (10) @(negedge clock);
    chk("x_nerr", 32'(n_erro - e0),   32'd1);
    chk("x_npr",  32'(n_pronto - p0), 32'd0);
    chk("x_ang",  32'(angulo), 32'h135);

    // wrong separator
    mark();
    send_frame("045;123#", -1);
    repeat (10) @(negedge clock);
    chk("sep_nerr", 32'(n_erro - e0),   32'd1);
    chk("sep_npr",  32'(n_pronto - p0), 32'd0);
    chk("sep_med",  32'(medida), 32'h007);

    // digit where '#' belongs, then a lone '#' to resynchronise
    mark();
    send_frame("045,1234", -1);
    send_frame("#", -1);
    repeat (10) @(negedge clock);
    chk("hash_nerr",   32'(n_erro - e0),   32'd1);
    chk("hash_npr",    32'(n_pronto - p0), 32'd0);
    chk("hash_estado", 32'(db_estado), 32'h0);
    mark();
    send_frame("270,300#", -1);
    repeat (10) @(negedge clock);
    chk("rec2_npr", 32'(n_pronto - p0), 32'd1);
    chk("rec2_ang", 32'(angulo), 32'h270);
    chk("rec2_med", 32'(medida), 32'h300);

    // short low glitch on an idle line
    mark();
    entrada_serial = 1'b0;
    repeat (CB / 4) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (3 * CB) @(negedge clock);
    chk("gl_nerr",   32'(n_erro - e0),   32'd0);
    chk("gl_npr",    32'(n_pronto - p0), 32'd0);
    chk("gl_dado",   32'(db_dado),   32'h23);
    chk("gl_estado", 32'(db_estado), 32'h0);
    mark();
    send_frame("001,002#", -1);
    repeat (10) @(negedge clock);
    chk("gl2_ang", 32'(angulo), 32'h001);
    chk("gl2_med", 32'(medida), 32'h002);

    // reset in the middle of the fifth character, held until the line is idle again
    mark();
    send_frame("123,", -1);
    fork
      send_char("4", 1'b0);
      begin
        repeat (3 * CB) @(negedge clock);
        reset = 1'b1;
      end
    join
    repeat (3) @(negedge clock);
    chk("mr_ang",    32'(angulo),    32'h0);
    chk("mr_med",    32'(medida),    32'h0);
    chk("mr_pronto", 32'(pronto),    32'h0);
    chk("mr_erro",   32'(erro),      32'h0);
    chk("mr_dado",   32'(db_dado),   32'h0);
    chk("mr_estado", 32'(db_estado), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    send_frame("359,888#", -1);
    repeat (10) @(negedge clock);
    chk("mr2_npr",  32'(n_pronto - p0), 32'd1);
    chk("mr2_nerr", 32'(n_erro - e0),   32'd0);
    chk("mr2_ang",  32'(angulo), 32'h359);
    chk("mr2_med",  32'(medida), 32'h888);

    chk("never_both", 32'(n_ambos), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
